load_store_unit: RTL and testbench

Initiator side of the data-memory port. It accepts single load/store requests from the core over a valid/ready handshake and drives funct3, dmem_wren, dmem_address and dmem_data_in toward the memory block. For loads it captures dmem_data_out one cycle after the access. It rejects misaligned or illegal accesses without touching memory and keeps 32-bit load/store counts.

---
 rtl/load_store_pkg.sv | 27 ++
 rtl/load_store_unit_if.sv | 50 +++++
 rtl/load_store_align_check.sv | 37 +++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_pkg.sv
// -----------------------------------------------------------------------------
// load_store_pkg
//   Shared types and constants for the load/store unit.
//   - lsu_state_t : transaction FSM states
//   - LB/LH/LW/LBU/LHU : RV32I load funct3 encodings
//   - SB/SH/SW         : RV32I store funct3 encodings
// -----------------------------------------------------------------------------
package load_store_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Core-side request/response handshake of the load/store unit.
//   Request : req_valid, req_ready, req_write, req_funct3, req_address,
//             req_wdata
//   Response: rsp_valid, rsp_ready, rsp_rdata, rsp_error
//   modport master : the core (issues requests, consumes responses)
//   modport slave  : the load/store unit
// -----------------------------------------------------------------------------
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid,
        output req_write,
        output req_funct3,
        output req_address,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_error
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_funct3,
        input  req_address,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_error
    );

endinterface

// File: rtl/load_store_align_check.sv
// -----------------------------------------------------------------------------
// load_store_align_check
//   Combinational legality check of a load/store request.
//   i_write   : 1 = store, 0 = load
//   i_funct3  : RV32I funct3
//   i_addr_lo : byte address bits [1:0]
//   o_illegal : misaligned access or unsupported funct3
// -----------------------------------------------------------------------------
module load_store_align_check
    import load_store_pkg::*;
(
    input  logic       i_write,
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_addr_lo,
    output logic       o_illegal
);

    always_comb begin
        o_illegal = 1'b0;
        if (i_write) begin
            case (i_funct3)
                SB:      o_illegal = 1'b0;
                SH:      o_illegal = i_addr_lo[0];
                SW:      o_illegal = |i_addr_lo;
                default: o_illegal = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                LB, LBU: o_illegal = 1'b0;
                LH, LHU: o_illegal = i_addr_lo[0];
                LW:      o_illegal = |i_addr_lo;
                default: o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the data-memory port. Accepts one load/store at a time
//   from the core, drives the memory command, captures load data one cycle
//   after the access and returns a response. Misaligned or illegal requests
//   are answered with rsp_error and never reach memory (when CHECK_ALIGN=1).
//
//   clk            : system clock, rising edge
//   reset          : asynchronous, active-low
//   bus            : core handshake (load_store_unit_if.slave)
//   funct3         : access size/sign to memory
//   dmem_wren      : write strobe to memory (ACCESS cycle of a store only)
//   dmem_address   : byte address to memory
//   dmem_data_in   : store data to memory
//   dmem_data_out  : load data from memory, valid the cycle after ACCESS
//   load_count     : completed non-error loads (wraps)
//   store_count    : completed non-error stores (wraps)
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    load_store_unit_if.slave         bus,
    output logic [2:0]               funct3,
    output logic                     dmem_wren,
    output logic [31:0]              dmem_address,
    output logic [31:0]              dmem_data_in,
    input  logic [31:0]              dmem_data_out,
    output logic [31:0]              load_count,
    output logic [31:0]              store_count
);

    lsu_state_t  r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic        r_write;
    logic [31:0] r_rdata;
    logic        r_error;
    logic [31:0] r_load_count;
    logic [31:0] r_store_count;

    logic        w_illegal_raw;
    logic        w_illegal;

    load_store_align_check u_align_check (
        .i_write   (bus.req_write),
        .i_funct3  (bus.req_funct3),
        .i_addr_lo (bus.req_address[1:0]),
        .o_illegal (w_illegal_raw)
    );

    assign w_illegal = CHECK_ALIGN ? w_illegal_raw : 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_funct3      <= '0;
            r_wdata       <= '0;
            r_write       <= 1'b0;
            r_rdata       <= '0;
            r_error       <= 1'b0;
            r_load_count  <= '0;
            r_store_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_addr   <= bus.req_address;
                        r_funct3 <= bus.req_funct3;
                        r_wdata  <= bus.req_wdata;
                        r_write  <= bus.req_write;
                        r_rdata  <= '0;
                        if (w_illegal) begin
                            r_error <= 1'b1;
                            r_state <= RESP;
                        end else begin
                            r_error <= 1'b0;
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Memory samples the command (and writes) at this edge.
                    if (r_write) begin
                        r_rdata       <= '0;
                        r_store_count <= r_store_count + 32'd1;
                        r_state       <= RESP;
                    end else begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_rdata      <= dmem_data_out;
                    r_load_count <= r_load_count + 32'd1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_error = r_error;

    // Decoded from state so that an asserted reset removes the strobe at once.
    assign dmem_wren    = (r_state == ACCESS) && r_write;
    assign funct3       = r_funct3;
    assign dmem_address = r_addr;
    assign dmem_data_in = r_wdata;

    assign load_count  = r_load_count;
    assign store_count = r_store_count;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import load_store_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if lsu ();
    load_store_unit_if lsu2 ();

    logic [2:0]  f3_1, f3_2;
    logic        wren_1, wren_2;
    logic [31:0] addr_1, addr_2, din_1, din_2, dout_1, dout_2;
    logic [31:0] lc_1, sc_1, lc_2, sc_2;

    load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (lsu),
        .funct3        (f3_1),
        .dmem_wren     (wren_1),
        .dmem_address  (addr_1),
        .dmem_data_in  (din_1),
        .dmem_data_out (dout_1),
        .load_count    (lc_1),
        .store_count   (sc_1)
    );

    load_store_unit #(.CHECK_ALIGN(1'b0)) dut_nochk (
        .clk           (clk),
        .reset         (reset),
        .bus           (lsu2),
        .funct3        (f3_2),
        .dmem_wren     (wren_2),
        .dmem_address  (addr_2),
        .dmem_data_in  (din_2),
        .dmem_data_out (dout_2),
        .load_count    (lc_2),
        .store_count   (sc_2)
    );

    assign dout_2 = 32'h1357_9BDF;

    // ---------------- memory responder ----------------
    logic [31:0] mem [0:255];
    logic [31:0] periph_reg = 32'h0;
    logic [31:0] timer_us = 32'h0;
    int unsigned pre = 0;
    int unsigned cyc = 0;
    int unsigned wren_cnt = 0;

    function automatic logic [31:0] raw_word(input logic [31:0] a);
        if (a[31:2] == 30'h3FFF_FFFF) return periph_reg;
        if (a[31:2] == 30'h3FFF_FFFE) return timer_us;
        if (a[31:10] == 22'h0) return mem[a[9:2]];
        return 32'h0;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lo);
        logic [31:0] s;
        s = w >> (8 * lo);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] m;
        m = old;
        case (f3)
            3'b000:  m[8*lo +: 8] = d[7:0];
            3'b001:  m[16*lo[1] +: 16] = d[15:0];
            default: m = d;
        endcase
        return m;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre == 99) begin
            pre <= 0;
            timer_us <= timer_us + 1;
        end else begin
            pre <= pre + 1;
        end
        dout_1 <= extend(raw_word(addr_1), f3_1, addr_1[1:0]);
        if (wren_1) begin
            if (addr_1[31:2] == 30'h3FFF_FFFF) periph_reg <= din_1;
            else if (addr_1[31:10] == 22'h0)
                mem[addr_1[9:2]] <= merge(mem[addr_1[9:2]], din_1, f3_1, addr_1[1:0]);
        end
    end

    always @(negedge clk) if (wren_1) wren_cnt <= wren_cnt + 1;

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_fail = 0;
    int exp_ld = 0;
    int exp_st = 0;
    int unsigned accept_cyc;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input bit cmp_data);
        rsp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: response with empty queue, got %h expected none",
                     lsu.rsp_rdata);
        end else begin
            e = sb_q.pop_front();
            if (cmp_data) check("rsp_rdata", lsu.rsp_rdata, e.rdata);
            check("rsp_error", {31'h0, lsu.rsp_error}, {31'h0, e.err});
        end
    endtask

    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input int exp_lat, input bit cmp_data,
                           output logic [31:0] got);
        int lat;
        int unsigned w0;
        rsp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        check("req_ready_idle", {31'h0, lsu.req_ready}, 32'h1);
        w0 = wren_cnt;
        lsu.req_valid   = 1'b1;
        lsu.req_write   = w;
        lsu.req_funct3  = f3;
        lsu.req_address = a;
        lsu.req_wdata   = wd;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        lsu.req_valid = 1'b0;
        if (!exp_err) begin
            check("dmem_address", addr_1, a);
            check("funct3", {29'h0, f3_1}, {29'h0, f3});
            check("dmem_data_in", din_1, wd);
        end
        lat = 1;
        while (!lsu.rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        got = lsu.rsp_rdata;
        pop_check(cmp_data);
        @(posedge clk);
        #1;
        check("rsp_valid_clear", {31'h0, lsu.rsp_valid}, 32'h0);
        check("wren_pulses", wren_cnt - w0, (w && !exp_err) ? 32'h1 : 32'h0);
        if (!exp_err) begin
            if (w) exp_st++;
            else   exp_ld++;
        end
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vecs[18];

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, t1, t2, d, keep;
        int unsigned c1;
        int lat;
        rsp_t e;

        vecs[0]  = '{1'b1, SW,     32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 2};
        vecs[1]  = '{1'b0, LW,     32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 3};
        vecs[2]  = '{1'b0, LB,     32'h13,       32'h0,        32'hFFFFFFDE, 1'b0, 3};
        vecs[3]  = '{1'b0, LBU,    32'h13,       32'h0,        32'h000000DE, 1'b0, 3};
        vecs[4]  = '{1'b0, LH,     32'h12,       32'h0,        32'hFFFFDEAD, 1'b0, 3};
        vecs[5]  = '{1'b1, SH,     32'h12,       32'h1234,     32'h0,        1'b0, 2};
        vecs[6]  = '{1'b0, LW,     32'h10,       32'h0,        32'h1234BEEF, 1'b0, 3};
        vecs[7]  = '{1'b0, LHU,    32'h12,       32'h0,        32'h00001234, 1'b0, 3};
        vecs[8]  = '{1'b0, LW,     32'h02,       32'h0,        32'h0,        1'b1, 1};
        vecs[9]  = '{1'b1, SH,     32'h03,       32'h5555,     32'h0,        1'b1, 1};
        vecs[10] = '{1'b1, SW,     32'h21,       32'h12345678, 32'h0,        1'b1, 1};
        vecs[11] = '{1'b0, LH,     32'h11,       32'h0,        32'h0,        1'b1, 1};
        vecs[12] = '{1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1, 1};
        vecs[13] = '{1'b1, 3'b100, 32'h10,       32'hFFFFFFFF, 32'h0,        1'b1, 1};
        vecs[14] = '{1'b1, SB,     32'h11,       32'h000000AB, 32'h0,        1'b0, 2};
        vecs[15] = '{1'b0, LW,     32'h10,       32'h0,        32'h1234ABEF, 1'b0, 3};
        vecs[16] = '{1'b1, SW,     32'hFFFFFFFC, 32'h80402010, 32'h0,        1'b0, 2};
        vecs[17] = '{1'b0, LW,     32'hFFFFFFFC, 32'h0,        32'h80402010, 1'b0, 3};

        lsu.req_valid = 1'b0; lsu.req_write = 1'b0; lsu.req_funct3 = 3'h0;
        lsu.req_address = 32'h0; lsu.req_wdata = 32'h0; lsu.rsp_ready = 1'b1;
        lsu2.req_valid = 1'b0; lsu2.req_write = 1'b0; lsu2.req_funct3 = 3'h0;
        lsu2.req_address = 32'h0; lsu2.req_wdata = 32'h0; lsu2.rsp_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {31'h0, lsu.rsp_valid}, 32'h0);
        check("rst_dmem_wren", {31'h0, wren_1}, 32'h0);
        check("rst_rsp_rdata", lsu.rsp_rdata, 32'h0);
        check("rst_rsp_error", {31'h0, lsu.rsp_error}, 32'h0);
        check("rst_dmem_address", addr_1, 32'h0);
        check("rst_load_count", lc_1, 32'h0);
        check("rst_store_count", sc_1, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'h0, lsu.req_ready}, 32'h1);

        // table-driven transactions
        for (int i = 0; i < 18; i++) begin
            run_req(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd,
                    vecs[i].err, vecs[i].lat, 1'b1, got);
        end
        check("load_count", lc_1, 32'(exp_ld));
        check("store_count", sc_1, 32'(exp_st));

        // backpressure: response held, new requests ignored
        keep = mem[16];
        e.rdata = 32'h1234ABEF;
        e.err = 1'b0;
        sb_q.push_back(e);
        lsu.rsp_ready = 1'b0;
        @(negedge clk);
        lsu.req_valid = 1'b1; lsu.req_write = 1'b0; lsu.req_funct3 = LW;
        lsu.req_address = 32'h10;
        @(posedge clk);
        #1;
        lsu.req_write = 1'b1; lsu.req_funct3 = SW;
        lsu.req_address = 32'h40; lsu.req_wdata = 32'h55555555;
        lat = 1;
        while (!lsu.rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_rsp_valid", {31'h0, lsu.rsp_valid}, 32'h1);
            check("bp_rsp_rdata", lsu.rsp_rdata, 32'h1234ABEF);
            check("bp_req_ready", {31'h0, lsu.req_ready}, 32'h0);
        end
        @(negedge clk);
        lsu.req_valid = 1'b0;
        lsu.rsp_ready = 1'b1;
        pop_check(1'b1);
        @(posedge clk);
        #1;
        exp_ld++;
        check("bp_after_rsp_valid", {31'h0, lsu.rsp_valid}, 32'h0);
        check("bp_after_req_ready", {31'h0, lsu.req_ready}, 32'h1);
        check("bp_ignored_store_mem", mem[16], keep);
        check("bp_store_count", sc_1, 32'(exp_st));
        check("bp_load_count", lc_1, 32'(exp_ld));

        // microsecond timer peripheral
        run_req(1'b0, LW, 32'hFFFFFFF8, 32'h0, 32'h0, 1'b0, 3, 1'b0, t1);
        c1 = accept_cyc;
        while (cyc < c1 + 10000 - 2) @(negedge clk);
        run_req(1'b0, LW, 32'hFFFFFFF8, 32'h0, 32'h0, 1'b0, 3, 1'b0, t2);
        d = t2 - t1;
        check("timer_delta_in_range", {31'h0, (d >= 32'd99 && d <= 32'd101)}, 32'h1);

        // reset during the ACCESS cycle of a store
        run_req(1'b1, SW, 32'h20, 32'h11111111, 32'h0, 1'b0, 2, 1'b1, got);
        @(negedge clk);
        lsu.req_valid = 1'b1; lsu.req_write = 1'b1; lsu.req_funct3 = SW;
        lsu.req_address = 32'h20; lsu.req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        lsu.req_valid = 1'b0;
        check("rst_mid_wren_before", {31'h0, wren_1}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_wren_drop", {31'h0, wren_1}, 32'h0);
        check("rst_mid_rsp_valid", {31'h0, lsu.rsp_valid}, 32'h0);
        check("rst_mid_load_count", lc_1, 32'h0);
        check("rst_mid_store_count", sc_1, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_ld = 0;
        exp_st = 0;
        @(negedge clk);
        check("rst_mid_req_ready", {31'h0, lsu.req_ready}, 32'h1);
        check("rst_mid_rsp_valid_after", {31'h0, lsu.rsp_valid}, 32'h0);
        check("rst_mid_mem_unchanged", mem[8], 32'h11111111);
        run_req(1'b0, LW, 32'h20, 32'h0, 32'h11111111, 1'b0, 3, 1'b1, got);
        check("post_rst_load_count", lc_1, 32'(exp_ld));
        check("post_rst_store_count", sc_1, 32'(exp_st));

        // unchecked instance: misaligned LW issues a real access
        @(negedge clk);
        lsu2.req_valid = 1'b1; lsu2.req_write = 1'b0; lsu2.req_funct3 = LW;
        lsu2.req_address = 32'h2;
        @(posedge clk);
        #1;
        lsu2.req_valid = 1'b0;
        check("nochk_dmem_address", addr_2, 32'h2);
        lat = 1;
        while (!lsu2.rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("nochk_latency", 32'(lat), 32'd3);
        check("nochk_rsp_error", {31'h0, lsu2.rsp_error}, 32'h0);
        check("nochk_rsp_rdata", lsu2.rsp_rdata, 32'h13579BDF);
        @(posedge clk);
        #1;
        check("nochk_load_count", lc_2, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
